serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial adder stage that accepts two WIDTH-bit operands over a valid/ready handshake. It adds them LSB-first, one bit per clock, using a single full-adder cell and a carry flip-flop, then presents the WIDTH-bit sum and carry-out on an output valid/ready handshake. It sits directly upstream of the combinational adder cells and is used where area matters more than throughput: one operand pair in flight, no overlap.

## Interface
Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..64

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair present on inA/inB
- in_ready  output  1  block can accept operands; high only in IDLE
- inA  input  WIDTH  first operand, unsigned
- inB  input  WIDTH  second operand, unsigned
- sub  input  1  1 = compute inA - inB; only present when SERIAL_ADDER_SUB_EN is defined
- out_valid  output  1  sum/Cout valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result, modulo 2^WIDTH
- Cout  output  1  carry-out of MSB; in subtract mode 1 = no borrow

## Operation
- States: IDLE, SHIFT, DONE.
- Reset (async, rst_n=0) puts state in IDLE and clears all registers, so sum=0, Cout=0 and out_valid=0. in_ready=1 because in_ready is decoded from state==IDLE.
- IDLE: in_ready=1. When in_valid=1, the operands are captured:
  - Load shA<=inA and shB<=inB (or ~inB when sub=1).
  - Set carry<=sub (carry<=0 when the macro is absent).
  - Set cnt<=0 and go to SHIFT.
  - in_valid=0 keeps the block in IDLE.
- SHIFT, once per cycle:
  - Compute bit = shA[0]^shB[0]^carry.
  - Update carry<=majority(shA[0],shB[0],carry).
  - Shift shA and shB right by one.
  - Shift the sum register right, inserting bit at position WIDTH-1.
  - Increment cnt.
  - When cnt==WIDTH-1, take this last shift, then go to DONE with Cout<=final carry.
  - in_valid is ignored.
- DONE: out_valid=1. sum and Cout are held stable until out_ready=1, which returns the block to IDLE. out_valid drops in the same edge.
- out_ready while not in DONE is ignored. in_valid while not in IDLE is not acknowledged, and the upstream must hold its data.
- cnt width is $clog2(WIDTH). Arithmetic wraps modulo 2^WIDTH, and overflow is visible only through Cout.
- sum is the internal shift register, so partial values are visible during SHIFT. Consumers must qualify sum with out_valid.

## Timing
- Operands are accepted at the edge where in_valid and in_ready are both high (edge 0).
- out_valid rises WIDTH+1 edges after acceptance. That is 1 edge into SHIFT, then WIDTH shift edges, with out_valid registered at the end of the last one. Result latency is therefore WIDTH+1 cycles.
- Minimum issue interval is WIDTH+2 cycles: the block returns to IDLE one edge after the out_ready handshake, and next acceptance can occur on the following edge.
- All outputs are registered except in_ready, which is a state decode. There are no combinational paths from inputs to outputs.
- A reset assertion mid-SHIFT or in DONE aborts the operation immediately:
  - the result is discarded and out_valid=0 asynchronously;
  - after release, the block is in IDLE with in_ready=1.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - The sub port exists.
  - When sub=1 at acceptance, the block computes inA + ~inB + 1.
  - Cout=1 means inA >= inB.
  - sub is sampled only at acceptance.
- SERIAL_ADDER_SUB_EN undefined:
  - No sub port.
  - Carry is initialised to 0 and inB is loaded as-is.
  - The block is an add-only stage.

## Structure
- serial_adder_pkg holds:
  - the state enum (IDLE, SHIFT, DONE) as a 2-bit typedef;
  - a CNT_W(width) constant function returning $clog2(width).
- One sub-module: serial_fa_cell, a combinational full adder with inputs inA, inB, cin and outputs sum and Cout. It is instantiated once and fed by shA[0], shB[0] and carry.

## Test plan
- WIDTH=8, 0x00+0x00 -> out_valid rises 9 cycles after accept, sum=0x00, Cout=0.
- 0xFF+0x01 -> sum=0x00, Cout=1. Then 0xA5+0x5A -> sum=0xFF, Cout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> sum and Cout unchanged, in_ready=0 throughout. Then out_ready=1 -> IDLE next edge, in_ready=1.
- in_valid held high continuously with new operands -> each accept separated by ≥10 cycles. Operands presented during SHIFT/DONE are never consumed.
- Pull rst_n low at cycle 4 of SHIFT -> out_valid=0, sum=0 and Cout=0 immediately. After release, 0x12+0x34 -> sum=0x46.
- With SERIAL_ADDER_SUB_EN, sub=1:
  - 0x05-0x07 -> sum=0xFE, Cout=0.
  - 0x07-0x05 -> sum=0x02, Cout=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state type and counter-width helper for the
// bit-serial adder stage.
package serial_adder_pkg;

   // Control states of the serial adder
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Width of the bit counter needed to index WIDTH shift steps
   function automatic int CNT_W(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// serial_fa_cell: single combinational full-adder cell that the serial adder
// reuses once per clock.
module serial_fa_cell (
   input  logic inA,
   input  logic inB,
   input  logic cin,
   output logic sum,
   output logic Cout
);

   assign sum  = inA ^ inB ^ cin;
   assign Cout = (inA & inB) | (inA & cin) | (inB & cin);

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, LSB first, one bit per clock,
// valid/ready on both sides, one operand pair in flight.
// Optional subtract support is compiled in with SERIAL_ADDER_SUB_EN
// (adds the sub port; sub=1 computes inA + ~inB + 1).
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] inA,
   input  logic [WIDTH-1:0] inB,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             Cout
);

   localparam int CW = CNT_W(WIDTH);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_sha;
   logic [WIDTH-1:0] r_shb;
   logic [WIDTH-1:0] r_sum;
   logic [CW-1:0]    r_cnt;
   logic             r_carry;
   logic             r_cout;
   logic             w_sub;
   logic             w_last;
   logic             w_fa_sum;
   logic             w_fa_cout;

`ifdef SERIAL_ADDER_SUB_EN
   assign w_sub = sub;
`else
   assign w_sub = 1'b0;
`endif

   assign w_last = (r_cnt == CW'(WIDTH - 1));

   serial_fa_cell u_fa (
      .inA  (r_sha[0]),
      .inB  (r_shb[0]),
      .cin  (r_carry),
      .sum  (w_fa_sum),
      .Cout (w_fa_cout)
   );

   // State register; reset aborts any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state decode: accept in IDLE, WIDTH shifts, hold result until taken
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (in_valid)  w_state_nxt = SHIFT;
         SHIFT:   if (w_last)    w_state_nxt = DONE;
         DONE:    if (out_ready) w_state_nxt = IDLE;
         default:                w_state_nxt = IDLE;
      endcase
   end

   // Datapath: operand capture, one full-adder step per SHIFT cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sha   <= '0;
         r_shb   <= '0;
         r_sum   <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_sha   <= inA;
                  // Two's complement subtract: invert B, inject 1 via carry-in
                  r_shb   <= w_sub ? ~inB : inB;
                  r_carry <= w_sub;
                  r_cnt   <= '0;
               end
            end
            SHIFT: begin
               r_carry <= w_fa_cout;
               r_sha   <= r_sha >> 1;
               r_shb   <= r_shb >> 1;
               r_sum   <= {w_fa_sum, r_sum[WIDTH-1:1]};
               r_cnt   <= r_cnt + 1'b1;
               if (w_last) r_cout <= w_fa_cout;
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign sum       = r_sum;
   assign Cout      = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder (WIDTH=8).
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] inA = '0;
   logic [7:0] inB = '0;
   logic       sub = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] sum;
   logic       Cout;

   int ntests = 0;
   int nfail  = 0;
   int lat;
   int n;

   serial_adder #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .inA       (inA),
      .inB       (inB),
`ifdef SERIAL_ADDER_SUB_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .Cout      (Cout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present operands at a negedge, wait for acceptance, then wait for out_valid.
   // Returns edges from acceptance (inclusive) to out_valid visible.
   task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s,
                        output int l);
      inA = a; inB = b; sub = s; in_valid = 1'b1;
      for (int k = 0; k < 50 && !in_ready; k++) @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      l = 1;
      while (!out_valid && l < 50) begin
         @(negedge clk);
         l++;
      end
   endtask

   task automatic take(input string tag);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_ov_drop"}, out_valid, 1'b0);
      chk({tag, "_idle"}, in_ready, 1'b1);
   endtask

   initial begin
      // Reset state
      #2;
      chk("rst_sum", sum, 8'h00);
      chk("rst_cout", Cout, 1'b0);
      chk("rst_ov", out_valid, 1'b0);
      chk("rst_ir", in_ready, 1'b1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 0x00 + 0x00, latency
      issue(8'h00, 8'h00, 1'b0, lat);
      chk("zero_lat", lat, 9);
      chk("zero_sum", sum, 8'h00);
      chk("zero_cout", Cout, 1'b0);
      take("zero");

      // Overflow wraps, visible only on Cout
      issue(8'hFF, 8'h01, 1'b0, lat);
      chk("ovf_lat", lat, 9);
      chk("ovf_sum", sum, 8'h00);
      chk("ovf_cout", Cout, 1'b1);
      take("ovf");

      issue(8'hA5, 8'h5A, 1'b0, lat);
      chk("a5_sum", sum, 8'hFF);
      chk("a5_cout", Cout, 1'b0);
      take("a5");

      // Backpressure: result held while out_ready=0
      issue(8'h80, 8'h80, 1'b0, lat);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_sum", sum, 8'h00);
         chk("bp_cout", Cout, 1'b1);
         chk("bp_ov", out_valid, 1'b1);
         chk("bp_ir", in_ready, 1'b0);
      end
      take("bp");

      // in_valid held high; operands changed during SHIFT must not be used
      inA = 8'h10; inB = 8'h20; in_valid = 1'b1; out_ready = 1'b1;
      chk("cont_ir", in_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      inA = 8'h77; inB = 8'h77;
      n = 1;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("cont_lat", n, 9);
      chk("cont_sum1", sum, 8'h30);
      inA = 8'h01; inB = 8'h02;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("cont_interval", n, 10);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; inA = 8'h77; inB = 8'h77;
      n = 1;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("cont_sum2", sum, 8'h03);
      chk("cont_cout2", Cout, 1'b0);
      @(negedge clk);
      out_ready = 1'b0;
      chk("cont_idle", in_ready, 1'b1);

      // Reset in the 4th SHIFT cycle: partial sum visible, then cleared
      inA = 8'hFF; inB = 8'hFF; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_partial", sum, 8'hC0);
      chk("mid_ir", in_ready, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_ov", out_valid, 1'b0);
      chk("mid_rst_sum", sum, 8'h00);
      chk("mid_rst_cout", Cout, 1'b0);
      chk("mid_rst_ir", in_ready, 1'b1);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("mid_rel_ir", in_ready, 1'b1);

      // Reset while in DONE drops out_valid at once
      issue(8'h80, 8'h80, 1'b0, lat);
      chk("done_pre_cout", Cout, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk("done_rst_ov", out_valid, 1'b0);
      chk("done_rst_cout", Cout, 1'b0);
      #1 rst_n = 1'b1;
      @(negedge clk);

      issue(8'h12, 8'h34, 1'b0, lat);
      chk("post_lat", lat, 9);
      chk("post_sum", sum, 8'h46);
      chk("post_cout", Cout, 1'b0);
      take("post");

`ifdef SERIAL_ADDER_SUB_EN
      issue(8'h05, 8'h07, 1'b1, lat);
      chk("sub_neg_sum", sum, 8'hFE);
      chk("sub_neg_cout", Cout, 1'b0);
      take("sub_neg");
      issue(8'h07, 8'h05, 1'b1, lat);
      chk("sub_pos_sum", sum, 8'h02);
      chk("sub_pos_cout", Cout, 1'b1);
      take("sub_pos");
      issue(8'h33, 8'h33, 1'b1, lat);
      chk("sub_eq_sum", sum, 8'h00);
      chk("sub_eq_cout", Cout, 1'b1);
      take("sub_eq");
`endif

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
